shl_share_arbiter: RTL

//  - Shares one combinational shl (shift-left) datapath unit among NREQ requesters.
//  - Round-robin arbitration; the winner's operands are captured and shifted.
//  - The result is registered and tagged with the winner's index.
//  - Sits between scheduled datapath states and the shared shifter resource,
//    so that one shl instance serves several operations.

---
 rtl/shl_share_arbiter_pkg.sv | 27 ++
 rtl/shl_share_arbiter_shl.sv | 21 ++
 rtl/shl_share_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/shl_share_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// shl_share_arbiter_pkg
//  Shared definitions for the shared-shifter arbiter:
//   - state_t : FSM state encoding (IDLE = 1'b0, EXEC = 1'b1)
//   - idw_for : requester-index width rule, clog2(NREQ) with a minimum of 1
// ----------------------------------------------------------------------------
package shl_share_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // The index width must be just wide enough to name every requester.
    function automatic int idw_for(input int nreq);
        int w;
        w = 0;
        while ((1 << w) < nreq) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/shl_share_arbiter_shl.sv
// ----------------------------------------------------------------------------
// shl_share_arbiter_shl
//  The shared combinational shift-left unit.
//  Logical shift with zero fill; bits shifted past the top are dropped, so any
//  shift amount of DATAWIDTH or more yields zero.
//  Ports:
//   a   in  DATAWIDTH  operand
//   sh  in  DATAWIDTH  shift amount
//   d   out DATAWIDTH  a << sh
// ----------------------------------------------------------------------------
module shl_share_arbiter_shl #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh,
    output logic [DATAWIDTH-1:0] d
);

    assign d = a << sh;

endmodule

// File: rtl/shl_share_arbiter.sv
// ----------------------------------------------------------------------------
// shl_share_arbiter
//  Lets NREQ requesters share one shift-left unit. A round-robin search picks
//  one requester per IDLE cycle, its operands are captured, shifted during the
//  following EXEC cycle, and the registered result is tagged with its index.
//  Ports:
//   Clk      in   1               clock, rising edge
//   Rst      in   1               synchronous reset, active-high
//   req      in   NREQ            per-requester request level
//   a_in     in   NREQ*DATAWIDTH  operands, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   sh_in    in   NREQ*DATAWIDTH  shift amounts, packed like a_in
//   gnt      out  NREQ            registered one-hot grant pulse
//   d_out    out  DATAWIDTH       registered shift result (held between results)
//   d_valid  out  1               one-cycle pulse marking d_out/d_id valid
//   d_id     out  IDW             requester index owning d_out
//   busy     out  1               high while the shifter is executing
// ----------------------------------------------------------------------------
module shl_share_arbiter
    import shl_share_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = idw_for(NREQ)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_in,
    input  logic [NREQ*DATAWIDTH-1:0] sh_in,
    output logic [NREQ-1:0]           gnt,
    output logic [DATAWIDTH-1:0]      d_out,
    output logic                      d_valid,
    output logic [IDW-1:0]            d_id,
    output logic                      busy
);

    state_t                state;
    state_t                next_state;
    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        win;
    logic [NREQ-1:0]       win_onehot;
    logic [DATAWIDTH-1:0]  op_a;
    logic [DATAWIDTH-1:0]  op_sh;
    logic [DATAWIDTH-1:0]  shl_res;
    logic [DATAWIDTH-1:0]  a_arr  [NREQ];
    logic [DATAWIDTH-1:0]  sh_arr [NREQ];

    // Search upward from the slot after the last winner, wrapping around, so
    // the most recent winner has the lowest priority next time.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] w;
        logic [IDW-1:0] cand;
        logic           found;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(p) + k) % NREQ);
            if (!found && r[cand]) begin
                w     = cand;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Split the packed operand buses into per-requester words.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]  = a_in[i*DATAWIDTH +: DATAWIDTH];
        assign sh_arr[i] = sh_in[i*DATAWIDTH +: DATAWIDTH];
    end

    // Winner and its one-hot grant pattern for the current request vector.
    always_comb begin
        win        = rr_pick(req, ptr);
        win_onehot = NREQ'(1) << win;
    end

    // The shifter only ever sees the captured operands, so requesters may
    // change their inputs as soon as they have been granted.
    shl_share_arbiter_shl #(
        .DATAWIDTH (DATAWIDTH)
    ) u_shl (
        .a  (op_a),
        .sh (op_sh),
        .d  (shl_res)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: any request moves to EXEC for exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req) next_state = EXEC;
            EXEC:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic derived directly from the state.
    always_comb begin
        busy = (state == EXEC);
    end

    // Datapath registers. gnt and d_valid are pulses and clear by default;
    // d_out and d_id keep their last value until the next result or grant.
    // A reset discards any operation in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr     <= IDW'(NREQ - 1);
            gnt     <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
            d_id    <= '0;
            op_a    <= '0;
            op_sh   <= '0;
        end else begin
            gnt     <= '0;
            d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        op_a  <= a_arr[win];
                        op_sh <= sh_arr[win];
                        gnt   <= win_onehot;
                        d_id  <= win;
                        ptr   <= win;
                    end
                end
                EXEC: begin
                    d_out   <= shl_res;
                    d_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
